err_inject_lanes: RTL and testbench

Parametrised, self-timed error injector that sits between the 8b/10b encoder output and the link model. It replaces the fixed single-word corruptor with several capabilities:
- a configurable lane count;
- selectable corruption modes (single bit, burst, whole symbol);
- a programmable injection period;
- an LFSR-driven error position;
- an injection counter for bench-side bit-error-rate bookkeeping.

Data passes through with one cycle of latency whether or not an error is injected.

---
 rtl/err_inject_lanes_pkg.sv | 21 ++
 rtl/err_inject_lanes_lfsr16.sv | 23 ++
 rtl/err_inject_lanes.sv | 140 ++++++++++++++
 tb/tb_err_inject_lanes.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_inject_lanes_pkg.sv
// Shared definitions for the lane error injector: mode encodings, the
// position LFSR polynomial and seed, and the LFSR step function.
package err_inject_lanes_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BIT   = 2'd1,
        MODE_BURST = 2'd2,
        MODE_SYM   = 2'd3
    } mode_e;

    // Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // One right-shift Galois step: the bit shifted out folds the taps back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/err_inject_lanes_lfsr16.sv
// 16-bit Galois LFSR: loads SEED on reset, advances one step per enabled cycle.
module lfsr16
    import err_inject_lanes_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    // State register: seed on reset, step when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  state_q <= SEED;
        else if (en) state_q <= lfsr_step(state_q);
    end

    assign state_o = state_q;

endmodule

// File: rtl/err_inject_lanes.sv
// Error injector between the 8b/10b encoder and the link model. Every beat
// passes through one register stage; on every period-th valid beat an
// LFSR-positioned XOR mask (single bit, wrapping burst, or whole lane)
// corrupts the data.
module err_inject_lanes
    import err_inject_lanes_pkg::*;
#(
    parameter int          LANES     = 8,
    parameter int          SYM_W     = 10,
    parameter int          PERIOD_W  = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_valid,
    input  logic [LANES*SYM_W-1:0]   din,
    input  logic                     inj_en,
    input  logic [1:0]               mode,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [3:0]               burst_len,
    input  logic                     clr_cnt,
    output logic                     dout_valid,
    output logic [LANES*SYM_W-1:0]   dout,
    output logic [LANES*SYM_W-1:0]   err_mask,
    output logic                     inj_pulse,
    output logic [15:0]              inj_count
);

    localparam int TOTAL_W = LANES * SYM_W;
    localparam int POS_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [15:0]          lfsr;
    logic                 lfsr_unused;
    mode_e                mode_s;
    logic [PERIOD_W-1:0]  eff_period;
    logic [3:0]           eff_burst;
    logic                 active;
    logic                 inj;
    logic [POS_W-1:0]     pos;
    logic [LANE_W-1:0]    lane;
    logic [TOTAL_W-1:0]   mask;
    int unsigned          off;

    logic [PERIOD_W-1:0]  pcnt_q, pcnt_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [TOTAL_W-1:0]   dout_q, mask_q;
    logic                 vld_q, pulse_q;

    // Position source advances once per accepted beat; the current state
    // positions this beat's error.
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (din_valid),
        .state_o (lfsr)
    );

    // Only the low byte selects a position.
    assign lfsr_unused = ^lfsr[15:8];

    assign mode_s     = mode_e'(mode);
    assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
    assign eff_burst  = (burst_len == '0) ? 4'd1 : burst_len;
    assign active     = inj_en && (mode_s != MODE_PASS);
    // >= keeps the counter from running away if period shrinks mid-count.
    assign inj        = din_valid && active && (pcnt_q >= eff_period - PERIOD_W'(1));

    // Scale the 8-bit random value onto [0, TOTAL_W) and [0, LANES).
    assign pos  = POS_W'((32'(lfsr[7:0]) * 32'(TOTAL_W)) >> 8);
    assign lane = LANE_W'((32'(lfsr[7:0]) * 32'(LANES)) >> 8);

    // Period counter: cleared while injection is off, advances on valid beats.
    always_comb begin
        pcnt_d = pcnt_q;
        if (!active)        pcnt_d = '0;
        else if (inj)       pcnt_d = '0;
        else if (din_valid) pcnt_d = pcnt_q + PERIOD_W'(1);
    end

    // Mask build: zero unless this beat is an injection beat.
    always_comb begin
        mask = '0;
        off  = 0;
        if (inj) begin
            case (mode_s)
                MODE_BIT:   mask[pos] = 1'b1;
                MODE_BURST: begin
                    // Bit i is set when its distance after pos (mod TOTAL_W)
                    // is inside the burst; long bursts saturate to all ones.
                    for (int i = 0; i < TOTAL_W; i++) begin
                        off = (i >= int'(pos)) ? 32'(i - int'(pos))
                                               : 32'(i + TOTAL_W - int'(pos));
                        if (off < 32'(eff_burst)) mask[i] = 1'b1;
                    end
                end
                MODE_SYM: begin
                    for (int l = 0; l < LANES; l++)
                        if (l == int'(lane)) mask[l*SYM_W +: SYM_W] = '1;
                end
                default: ;
            endcase
        end
    end

    // Saturating injection counter; clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)                    cnt_d = '0;
        else if (inj && cnt_q != '1)    cnt_d = cnt_q + 16'd1;
    end

    // Output stage: data/mask hold across gaps, valid and pulse track each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            pulse_q <= 1'b0;
            dout_q  <= '0;
            mask_q  <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= din_valid;
            pulse_q <= inj;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            if (din_valid) begin
                dout_q <= din ^ mask;
                mask_q <= mask;
            end
        end
    end

    assign dout_valid = vld_q;
    assign dout       = dout_q;
    assign err_mask   = mask_q;
    assign inj_pulse  = pulse_q;
    assign inj_count  = cnt_q;

endmodule

// File: tb/tb_err_inject_lanes.sv
// Bench for err_inject_lanes: a beat-level model predicts every output
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_err_inject_lanes;

    localparam int LANES = 8;
    localparam int SW    = 10;
    localparam int TW    = LANES * SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_valid = 1'b0;
    logic [TW-1:0] din = '0;
    logic          inj_en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   period = 16'd1;
    logic [3:0]    burst_len = 4'd1;
    logic          clr_cnt = 1'b0;
    logic          dout_valid, inj_pulse;
    logic [TW-1:0] dout, err_mask;
    logic [15:0]   inj_count;

    // second instance, seeded so its first position is bit 78
    logic          v2 = 1'b0;
    logic          dv2, ip2;
    logic [TW-1:0] dout2, mask2;
    logic [15:0]   cnt2;

    logic [15:0]   gen;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [63:0]   hist = '0;

    always #5 clk = ~clk;

    err_inject_lanes #(.LANES(LANES), .SYM_W(SW), .PERIOD_W(16), .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .inj_en(inj_en),
        .mode(mode), .period(period), .burst_len(burst_len), .clr_cnt(clr_cnt),
        .dout_valid(dout_valid), .dout(dout), .err_mask(err_mask),
        .inj_pulse(inj_pulse), .inj_count(inj_count));

    err_inject_lanes #(.LANES(LANES), .SYM_W(SW), .PERIOD_W(16), .LFSR_SEED(16'hACFA)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(v2), .din({TW{1'b0}}), .inj_en(1'b1),
        .mode(2'd2), .period(16'd1), .burst_len(4'd5), .clr_cnt(1'b0),
        .dout_valid(dv2), .dout(dout2), .err_mask(mask2),
        .inj_pulse(ip2), .inj_count(cnt2));

    // stimulus data source
    lfsr16 #(.SEED(16'h1234)) u_gen (.clk(clk), .rst_n(rst_n), .en(1'b1), .state_o(gen));

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [TW-1:0] m_mask(input logic [15:0] s, input logic [1:0] md,
                                            input logic [3:0] bl);
        logic [TW-1:0] m;
        int p, ln, b;
        m  = '0;
        p  = int'(s[7:0]) * TW / 256;
        ln = int'(s[7:0]) * LANES / 256;
        b  = (bl == 0) ? 1 : int'(bl);
        case (md)
            2'd1: m[p] = 1'b1;
            2'd2: for (int k = 0; k < b; k++) m[(p + k) % TW] = 1'b1;
            2'd3: for (int j = 0; j < SW; j++) m[ln*SW + j] = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

    logic [15:0]   m_lfsr;
    int            m_seen;     // valid beats since enable / last injection
    logic          e_valid, e_pulse;
    logic [TW-1:0] e_dout, e_mask;
    logic [15:0]   e_count;

    function automatic bit m_inj();
        int p;
        p = (period == 0) ? 1 : int'(period);
        return din_valid && inj_en && (mode != 2'd0) && (m_seen + 1 == p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1; m_seen <= 0;
            e_valid <= 1'b0; e_pulse <= 1'b0; e_dout <= '0; e_mask <= '0; e_count <= '0;
        end else begin
            e_valid <= din_valid;
            e_pulse <= m_inj();
            if (!inj_en || mode == 2'd0) m_seen <= 0;
            else if (din_valid)          m_seen <= m_inj() ? 0 : m_seen + 1;
            if (din_valid) begin
                e_mask <= m_inj() ? m_mask(m_lfsr, mode, burst_len) : '0;
                e_dout <= din ^ (m_inj() ? m_mask(m_lfsr, mode, burst_len) : '0);
                m_lfsr <= m_step(m_lfsr);
            end
            if (clr_cnt)                          e_count <= '0;
            else if (m_inj() && e_count != 16'hFFFF) e_count <= e_count + 16'd1;
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        chk("dout_valid", dout_valid, e_valid);
        if (e_valid) begin
            chk("dout", dout, e_dout);
            chk("err_mask", err_mask, e_mask);
            chk("inj_pulse", inj_pulse, e_pulse);
        end
        chk("inj_count", inj_count, e_count);
        if (dout_valid) hist <= {hist[62:0], inj_pulse};
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [TW-1:0] d);
        @(negedge clk);
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        drive(1'b0, '0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int zl, fl;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, '0);
        chk("rst_mask", err_mask, '0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_pulse", inj_pulse, 1'b0);
        chk("rst_count", inj_count, '0);
        @(negedge clk) rst_n = 1'b1;

        // pass-through
        mode = 2'd0; inj_en = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, (i < 5) ? '0 : {5{gen}});
        settle();
        chk("pass_hist", hist[9:0], 10'h0);
        chk("pass_count", inj_count, 16'd0);

        // single-bit, period 4, back-to-back
        mode = 2'd1; period = 16'd4;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, {5{gen}});
            if (inj_pulse) chk("bit_popcount", $countones(err_mask), 1);
            chk("bit_xor", dout ^ err_mask, din);
        end
        settle();
        chk("bit_hist", hist[15:0], 16'h1111);
        chk("bit_count", inj_count, 16'd4);

        // burst on the seeded instance: pos 78, wraps to 0..2
        @(negedge clk) v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        chk("burst_wrap_mask", mask2, 80'hC000_0000_0000_0000_0007);
        chk("burst_wrap_pop", $countones(mask2), 5);
        chk("burst_wrap_pulse", ip2, 1'b1);

        // burst on the main instance, then burst_len 0
        mode = 2'd2; burst_len = 4'd5; period = 16'd2;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, {5{gen}});
            if (inj_pulse) chk("burst_pop", $countones(err_mask), 5);
        end
        burst_len = 4'd0; period = 16'd1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {5{gen}});
            chk("burst0_pop", $countones(err_mask), 1);
        end

        // symbol invert on all-ones data
        mode = 2'd3;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, {TW{1'b1}});
            zl = 0; fl = 0;
            for (int l = 0; l < LANES; l++) begin
                if (dout[l*SW +: SW] == 10'h000) zl++;
                if (dout[l*SW +: SW] == 10'h3FF) fl++;
            end
            chk("sym_zero_lanes", zl, 1);
            chk("sym_full_lanes", fl, LANES - 1);
        end

        // gaps: period 3 with valid toggling
        inj_en = 1'b0;
        settle();
        inj_en = 1'b1; mode = 2'd1; period = 16'd3;
        for (int i = 0; i < 12; i++) drive(i % 2 == 0, {5{gen}});
        settle();
        chk("gap_hist", hist[5:0], 6'b001001);

        // enable drop on the would-be injection beat
        for (int i = 0; i < 6; i++) begin
            inj_en = (i != 2);
            drive(1'b1, {5{gen}});
        end
        settle();
        chk("drop_hist", hist[5:0], 6'b000001);

        // reset mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, {5{gen}});
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, '0);
        chk("mid_rst_mask", err_mask, '0);
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_count", inj_count, '0);
        din_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // first beat after release positions from the seed: bit 70
        mode = 2'd1; period = 16'd1; inj_en = 1'b1;
        drive(1'b1, '0);
        chk("seed_mask", err_mask, 80'h0040_0000_0000_0000_0000);
        chk("seed_dout", dout, 80'h0040_0000_0000_0000_0000);
        chk("seed_pulse", inj_pulse, 1'b1);

        // saturation
        for (int i = 0; i < 65540; i++) drive(1'b1, {5{gen}});
        chk("sat_count", inj_count, 16'hFFFF);
        clr_cnt = 1'b1;
        drive(1'b1, {5{gen}});
        clr_cnt = 1'b0;
        chk("clr_pulse", inj_pulse, 1'b1);
        chk("clr_count", inj_count, 16'd0);
        drive(1'b1, {5{gen}});
        chk("after_clr_count", inj_count, 16'd1);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
